// File: rtl/clock_sched.sv
// Time-of-day clock with a single armable alarm, driven by a 1 Hz tick strobe.
// All outputs are registered: inputs sampled at one mclk edge show up right after that edge.
module clock_sched #(
  parameter int ALARM_SECS = 30
) (
  input  logic       mclk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       set,
  input  logic [4:0] nowH,
  input  logic [5:0] nowM,
  input  logic [4:0] timerH,
  input  logic [5:0] timerM,
  input  logic       run_enable,
  input  logic       alarm_ack,
  output logic [4:0] curH,
  output logic [5:0] curM,
  output logic [5:0] curS,
  output logic       alarm,
  output logic       min_tick,
  output logic       err,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    ARMED   = 2'd2,
    RINGING = 2'd3
  } state_t;

  state_t     state_q;
  logic [4:0] cur_h_q;
  logic [5:0] cur_m_q;
  logic [5:0] cur_s_q;
  logic [5:0] ring_q;
  logic       alarm_q;
  logic       min_tick_q;
  logic       err_q;
  logic       run_en_q;

  logic [4:0] inc_h_d;
  logic [5:0] inc_m_d;
  logic [5:0] inc_s_d;
  logic       sec_wrap;
  logic       set_ok;
  logic       timer_ok;
  logic       rise;
  logic       match;

  // Next time-of-day one second on, plus the alarm match on that incremented value.
  always_comb begin
    sec_wrap = (cur_s_q == 6'd59);
    inc_s_d  = sec_wrap ? 6'd0 : cur_s_q + 6'd1;
    inc_m_d  = cur_m_q;
    inc_h_d  = cur_h_q;
    if (sec_wrap) begin
      inc_m_d = (cur_m_q == 6'd59) ? 6'd0 : cur_m_q + 6'd1;
      if (cur_m_q == 6'd59) begin
        inc_h_d = (cur_h_q == 5'd23) ? 5'd0 : cur_h_q + 5'd1;
      end
    end
    match    = (inc_s_d == 6'd0) && (inc_h_d == timerH) && (inc_m_d == timerM);
    set_ok   = set && (nowH <= 5'd23) && (nowM <= 6'd59);
    timer_ok = (timerH <= 5'd23) && (timerM <= 6'd59);
    rise     = run_enable && !run_en_q;
  end

  always_ff @(posedge mclk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_h_q    <= 5'd0;
      cur_m_q    <= 6'd0;
      cur_s_q    <= 6'd0;
      ring_q     <= 6'd0;
      alarm_q    <= 1'b0;
      min_tick_q <= 1'b0;
      err_q      <= 1'b0;
      run_en_q   <= 1'b0;
    end else begin
      run_en_q   <= run_enable;
      min_tick_q <= 1'b0;
      err_q      <= 1'b0;

      // A load always wins over the tick; an invalid load only flags err.
      if (set) begin
        if (set_ok) begin
          cur_h_q <= nowH;
          cur_m_q <= nowM;
          cur_s_q <= 6'd0;
        end else begin
          err_q <= 1'b1;
        end
      end else if (tick && state_q != IDLE) begin
        cur_h_q    <= inc_h_d;
        cur_m_q    <= inc_m_d;
        cur_s_q    <= inc_s_d;
        min_tick_q <= sec_wrap;
      end

      case (state_q)
        IDLE: begin
          if (set_ok) state_q <= RUN;
        end
        RUN: begin
          if (rise) begin
            if (timer_ok) state_q <= ARMED;
            else          err_q   <= 1'b1;
          end
        end
        ARMED: begin
          if (!set && tick && match) begin
            state_q <= RINGING;
            alarm_q <= 1'b1;
            ring_q  <= 6'(ALARM_SECS);
          end
        end
        RINGING: begin
          if (alarm_ack || set) begin
            state_q <= RUN;
            alarm_q <= 1'b0;
            ring_q  <= 6'd0;
          end else if (tick) begin
            if (ring_q == 6'd1) begin
              state_q <= RUN;
              alarm_q <= 1'b0;
              ring_q  <= 6'd0;
            end else begin
              ring_q <= ring_q - 6'd1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign curH     = cur_h_q;
  assign curM     = cur_m_q;
  assign curS     = cur_s_q;
  assign alarm    = alarm_q;
  assign min_tick = min_tick_q;
  assign err      = err_q;
  assign state    = state_q;

endmodule

// File: doc/clock_sched.md
CLOCK_SCHED -- requirements
Module: clock_sched

Interface
REQ-001 SHALL have parameter ALARM_SECS, default 30, the number of ticks the alarm stays asserted when not acknowledged (legal range 1..63).
REQ-002 SHALL have port mclk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port tick, input, 1 bit: one-cycle 1 Hz time-base pulse.
REQ-005 SHALL have port set, input, 1 bit: one-cycle load request for current time.
REQ-006 SHALL have ports nowH (5 bits) and nowM (6 bits), inputs: time to load on set.
REQ-007 SHALL have ports timerH (5 bits) and timerM (6 bits), inputs: alarm target time.
REQ-008 SHALL have port run_enable, input, 1 bit: level input; its rising edge arms the alarm.
REQ-009 SHALL have port alarm_ack, input, 1 bit: one-cycle alarm acknowledge.
REQ-010 SHALL have ports curH (5 bits), curM (6 bits) and curS (6 bits), outputs: running time of day.
REQ-011 SHALL have port alarm, output, 1 bit: high while the alarm is ringing.
REQ-012 SHALL have port min_tick, output, 1 bit: one-cycle pulse on each seconds wrap.
REQ-013 SHALL have port err, output, 1 bit: one-cycle pulse when a load or arm request is rejected.
REQ-014 SHALL have port state, output, 2 bits, with encoding IDLE=0, RUN=1, ARMED=2, RINGING=3.

Function
REQ-015 SHALL register all outputs; an input sampled at edge N is reflected on the outputs after edge N.
REQ-016 SHALL, in state IDLE, hold curH:curM:curS and ignore both tick and the run_enable edge.
REQ-017 SHALL, on set with nowH<=23 and nowM<=59, load curH=nowH, curM=nowM and curS=0, and move IDLE to RUN; in any other state, set SHALL leave the state unchanged, except as given in REQ-024.
REQ-018 SHALL, on set with nowH>23 or nowM>59, pulse err and leave the time and state unchanged.
REQ-019 SHALL give set priority over tick in the same cycle: the loaded value is applied with no increment.
REQ-020 SHALL, on tick in RUN, ARMED or RINGING, increment curS; curS wraps 59->0 and increments curM with min_tick=1; curM wraps 59->0 and increments curH; curH wraps 23->0.
REQ-021 SHALL detect the run_enable rising edge using a registered copy of run_enable (reset value 0). In RUN, an edge with timerH<=23 and timerM<=59 moves to ARMED; an edge with out-of-range timer values pulses err and stays in RUN. In ARMED or RINGING, the edge is ignored.
REQ-022 SHALL, in ARMED on a tick whose post-increment value is curS=0, curH=timerH and curM=timerM, enter RINGING with alarm=1 on the same edge, and load the ring counter with ALARM_SECS.
REQ-023 SHALL, in RINGING, decrement the ring counter on each tick; when a tick finds the counter at 1, it SHALL clear alarm and return to RUN.
REQ-024 SHALL, on alarm_ack or set while in RINGING, clear alarm and go to RUN on that edge; set also loads the time per REQ-017/018.
REQ-025 SHALL give an acknowledge priority over the ring-counter expiry and over a match in the same cycle.
REQ-026 SHALL ignore alarm_ack outside RINGING.
REQ-027 SHALL, after the alarm ends, return to RUN disarmed; a new run_enable rising edge is required to re-arm.
REQ-028 SHALL compare timerH and timerM as sampled on the matching tick cycle, not as sampled at arm time.

Reset
REQ-029 SHALL, when rst_n=0 at a rising edge, set curH=curM=curS=0, alarm=0, min_tick=0, err=0, state=IDLE, clear the ring counter and clear the registered run_enable copy; reset overrides all other inputs.
REQ-030 SHALL apply reset asserted mid-operation (including RINGING) with the same result at the next edge.

Verification
REQ-031 SHALL cover: reset, set 23:59 (curS=0), then 60 ticks -> 00:00:00, state=RUN, and exactly one min_tick pulse on the 60th tick.
REQ-032 SHALL cover: set with nowH=24, nowM=10 in IDLE -> err=1 for one cycle, state=IDLE, and time 00:00:00 unchanged.
REQ-033 SHALL cover: set 07:29, timer 07:30, run_enable 0->1 -> ARMED; on the 60th tick -> 07:30:00 with alarm=1 and state=RINGING; 30 more ticks -> alarm=0, state=RUN, time 07:30:30.
REQ-034 SHALL cover: in RINGING, alarm_ack pulse -> alarm=0 and state=RUN on the next edge while time continues; a later 07:30 occurrence without re-arm produces no alarm.
REQ-035 SHALL cover: set 12:00 coincident with tick -> 12:00:00 exactly, with no increment.
REQ-036 SHALL cover: rst_n=0 for one cycle during RINGING -> all outputs zero and state=IDLE; with run_enable held high, an edge is seen but ignored in IDLE.
